// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - handshake FSM state encoding
//   - data word / byte-enable widths
//   - wait-counter width (covers LATENCY values 0..15)
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W      = 32;
    localparam int BE_W        = 4;
    localparam int CNT_W       = 4;
    localparam int LATENCY_MAX = (1 << CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage : dmem_pkg

// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank
// Synchronous single-port RAM, 2**ADDR_W words of WORD_W bits, with one write
// enable per byte lane and a registered read port. The read register samples
// mem[addr] on every rising edge. INIT_FILE is accepted for interface
// compatibility; storage starts uninitialised.
//
// Ports:
//   clk    in   clock, rising edge
//   we     in   BE_W   per-lane write enables (lane i = bits 8i+7:8i)
//   addr   in   ADDR_W word address shared by read and write
//   wdata  in   WORD_W write data, lane-aligned
//   rdata  out  WORD_W registered read data (mem[addr] of previous edge)
// -----------------------------------------------------------------------------
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = ""
) (
    input  logic                clk,
    input  logic [BE_W-1:0]     we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WORD_W-1:0]   wdata,
    output logic [WORD_W-1:0]   rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] rdata_reg;

    // Byte-lane writes and read-before-write registered read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule : dmem_bank

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the MEM-stage request interface. A request is
// captured in IDLE when mreq is high, held for LATENCY wait cycles, then one
// byte-masked write (w_mem != 0) or one 32-bit read (w_mem == 0) is performed
// and mres is raised. mres stays high until mreq is seen low.
//
// Ports:
//   clk         in   clock, rising edge
//   resetn      in   asynchronous active-low reset
//   mreq        in   request level
//   w_mem       in   4      byte-write mask, 0 = read
//   addr_mem    in   ADDR_W word address
//   store_data  in   32     write data, lane-aligned
//   load_data   out  32     registered read data
//   mres        out  acknowledge level
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mreq,
    input  logic [BE_W-1:0]     w_mem,
    input  logic [ADDR_W-1:0]   addr_mem,
    input  logic [WORD_W-1:0]   store_data,
    output logic [WORD_W-1:0]   load_data,
    output logic                mres
);

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [BE_W-1:0]      mask_reg;
    logic [WORD_W-1:0]    data_reg;
    logic [WORD_W-1:0]    load_data_reg;
    logic                 mres_reg;

    logic                 access;
    logic [BE_W-1:0]      bank_we;
    logic [ADDR_W-1:0]    bank_addr;
    logic [WORD_W-1:0]    bank_rdata;

    // The access edge is the WAIT edge on which the counter has run out.
    assign access  = (state_reg == WAIT) && (cnt_reg == '0);
    assign bank_we = access ? mask_reg : '0;

    // In IDLE the bank reads the live address so that, even with LATENCY = 0,
    // the registered read word for the captured address is ready by the
    // access edge. Afterwards only the captured address is used, so input
    // changes during WAIT cannot leak into the access.
    assign bank_addr = (state_reg == IDLE) ? addr_mem : addr_reg;

    dmem_bank #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (data_reg),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            mask_reg      <= '0;
            data_reg      <= '0;
            load_data_reg <= '0;
            mres_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mreq) begin
                        addr_reg  <= addr_mem;
                        mask_reg  <= w_mem;
                        data_reg  <= store_data;
                        cnt_reg   <= CNT_W'(LATENCY);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        // Write happens in the bank via bank_we this edge.
                        if (mask_reg == '0) begin
                            load_data_reg <= bank_rdata;
                        end
                        mres_reg  <= 1'b1;
                        state_reg <= ACK;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ACK: begin
                    if (!mreq) begin
                        mres_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign load_data = load_data_reg;
    assign mres      = mres_reg;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Four instances with LATENCY 1, 0, 15, 4
// share clock and reset; each scenario task drives one instance and checks
// results against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        resetn;
    logic        mreq       [4];
    logic [3:0]  w_mem      [4];
    logic [7:0]  addr_mem   [4];
    logic [31:0] store_data [4];
    logic [31:0] load_data  [4];
    logic        mres       [4];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_lat1 (
        .clk(clk), .resetn(resetn), .mreq(mreq[0]), .w_mem(w_mem[0]),
        .addr_mem(addr_mem[0]), .store_data(store_data[0]),
        .load_data(load_data[0]), .mres(mres[0]));

    dmem_responder #(.ADDR_W(8), .LATENCY(0)) u_lat0 (
        .clk(clk), .resetn(resetn), .mreq(mreq[1]), .w_mem(w_mem[1]),
        .addr_mem(addr_mem[1]), .store_data(store_data[1]),
        .load_data(load_data[1]), .mres(mres[1]));

    dmem_responder #(.ADDR_W(8), .LATENCY(15)) u_lat15 (
        .clk(clk), .resetn(resetn), .mreq(mreq[2]), .w_mem(w_mem[2]),
        .addr_mem(addr_mem[2]), .store_data(store_data[2]),
        .load_data(load_data[2]), .mres(mres[2]));

    dmem_responder #(.ADDR_W(8), .LATENCY(4)) u_lat4 (
        .clk(clk), .resetn(resetn), .mreq(mreq[3]), .w_mem(w_mem[3]),
        .addr_mem(addr_mem[3]), .store_data(store_data[3]),
        .load_data(load_data[3]), .mres(mres[3]));

    // Called at #1 after the capture edge: counts edges until mres is high.
    task automatic wait_mres(input int idx, output int lat);
        lat = 0;
        while (mres[idx] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (mres[idx] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL mres_timeout dut%0d: mres=%b after %0d edges, required 1", idx, mres[idx], lat);
        end
    endtask

    // Drops mreq and waits for mres to fall on the following edge.
    task automatic release_req(input int idx);
        int n;
        mreq[idx]  = 1'b0;
        w_mem[idx] = 4'h0;
        n = 0;
        while (mres[idx] !== 1'b0 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        if (n != 1) begin
            checks++;
            errors++;
            $display("FAIL mres_release dut%0d: mres fell after %0d edges, required 1", idx, n);
        end
    endtask

    // One full transaction; entered and left at #1 after a clock edge.
    task automatic txn(input int idx, input logic [7:0] a, input logic [3:0] m,
                       input logic [31:0] d, output logic [31:0] rd, output int lat);
        mreq[idx]       = 1'b1;
        addr_mem[idx]   = a;
        w_mem[idx]      = m;
        store_data[idx] = d;
        @(posedge clk); #1;
        wait_mres(idx, lat);
        rd = load_data[idx];
        release_req(idx);
        $display("txn dut%0d addr=%h mask=%b data=%h -> load_data=%h latency=%0d", idx, a, m, d, rd, lat);
    endtask

    task automatic test_reset;
        int bad;
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mreq[i] = 1'b0; w_mem[i] = 4'h0; addr_mem[i] = 8'h0; store_data[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        // Start a write on the LATENCY=1 instance and abort it in WAIT.
        mreq[0] = 1'b1; addr_mem[0] = 8'h40; w_mem[0] = 4'hF; store_data[0] = 32'h1234_5678;
        @(posedge clk); #1;
        resetn = 1'b0;
        mreq[0] = 1'b0; w_mem[0] = 4'h0;
        #1;
        checks++;
        if (mres[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mres: mres=%b, required 0", mres[0]);
        end
        checks++;
        if (load_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_load_data: load_data=%h, required 00000000", load_data[0]);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (mres[i] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle_mres: mres high on %0d samples, required 0", bad);
        end
        $display("reset sequence done");
    endtask

    task automatic test_word_rw;
        logic [31:0] rd;
        int lat;
        txn(0, 8'h10, 4'hF, 32'hDEAD_BEEF, rd, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL word_write_latency: %0d edges, required 2", lat);
        end
        txn(0, 8'h10, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL word_read_data: load_data=%h, required deadbeef", rd);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL word_read_latency: %0d edges, required 2", lat);
        end
        // A write must leave load_data unchanged.
        txn(0, 8'h11, 4'hF, 32'h1234_5678, rd, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_keeps_load_data: load_data=%h, required deadbeef", rd);
        end
    endtask

    task automatic test_byte_masks;
        logic [31:0] rd;
        int lat;
        txn(0, 8'h20, 4'hF, 32'h1122_3344, rd, lat);
        txn(0, 8'h20, 4'b0100, 32'h00AA_0000, rd, lat);
        txn(0, 8'h20, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h11AA_3344) begin
            errors++;
            $display("FAIL byte_mask_0100: load_data=%h, required 11aa3344", rd);
        end
        txn(0, 8'h20, 4'b0011, 32'h0000_BEEF, rd, lat);
        txn(0, 8'h20, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h11AA_BEEF) begin
            errors++;
            $display("FAIL half_mask_0011: load_data=%h, required 11aabeef", rd);
        end
        txn(0, 8'h20, 4'b1001, 32'hAABB_CCDD, rd, lat);
        txn(0, 8'h20, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hAAAA_BEDD) begin
            errors++;
            $display("FAIL sparse_mask_1001: load_data=%h, required aaaabedd", rd);
        end
    endtask

    task automatic test_input_stability;
        logic [31:0] rd;
        int lat;
        txn(3, 8'h05, 4'hF, 32'h0000_0005, rd, lat);
        txn(3, 8'h06, 4'hF, 32'h6666_6666, rd, lat);
        mreq[3] = 1'b1; addr_mem[3] = 8'h05; w_mem[3] = 4'h0; store_data[3] = 32'h0;
        @(posedge clk); #1;
        addr_mem[3] = 8'h06; w_mem[3] = 4'hF; store_data[3] = 32'hFFFF_FFFF;
        wait_mres(3, lat);
        rd = load_data[3];
        release_req(3);
        $display("txn dut3 addr=05 read with inputs changed in wait -> load_data=%h latency=%0d", rd, lat);
        checks++;
        if (rd !== 32'h0000_0005) begin
            errors++;
            $display("FAIL stability_read: load_data=%h, required 00000005", rd);
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL stability_latency: %0d edges, required 5", lat);
        end
        txn(3, 8'h06, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h6666_6666) begin
            errors++;
            $display("FAIL stability_mem06: load_data=%h, required 66666666", rd);
        end
    endtask

    task automatic test_hold;
        int lat;
        int bad_mres;
        int bad_load;
        mreq[0] = 1'b1; addr_mem[0] = 8'h10; w_mem[0] = 4'h0; store_data[0] = 32'h0;
        @(posedge clk); #1;
        wait_mres(0, lat);
        bad_mres = 0;
        bad_load = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mres[0] !== 1'b1) bad_mres++;
            if (load_data[0] !== 32'hDEAD_BEEF) bad_load++;
        end
        $display("hold dut0 addr=10 held 10 cycles: load_data=%h mres=%b", load_data[0], mres[0]);
        checks++;
        if (bad_mres != 0) begin
            errors++;
            $display("FAIL hold_mres: mres low on %0d of 10 cycles, required 0", bad_mres);
        end
        checks++;
        if (bad_load != 0) begin
            errors++;
            $display("FAIL hold_load_data: load_data wrong on %0d of 10 cycles, required 0", bad_load);
        end
        release_req(0);
    endtask

    task automatic test_latency_sweep;
        logic [31:0] rd;
        int lat;
        txn(1, 8'h50, 4'hF, 32'h0BAD_F00D, rd, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL latency0_write: %0d edges, required 1", lat);
        end
        txn(1, 8'h50, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h0BAD_F00D || lat != 1) begin
            errors++;
            $display("FAIL latency0_read: load_data=%h latency=%0d, required 0badf00d latency 1", rd, lat);
        end
        txn(2, 8'hFF, 4'hF, 32'hCAFE_0123, rd, lat);
        checks++;
        if (lat != 16) begin
            errors++;
            $display("FAIL latency15_write: %0d edges, required 16", lat);
        end
        txn(2, 8'hFF, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hCAFE_0123 || lat != 16) begin
            errors++;
            $display("FAIL latency15_read: load_data=%h latency=%0d, required cafe0123 latency 16", rd, lat);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd;
        int lat;
        txn(3, 8'h30, 4'hF, 32'h0, rd, lat);
        txn(3, 8'h05, 4'h0, 32'h0, rd, lat);  // load_data = 5 before the abort
        mreq[3] = 1'b1; addr_mem[3] = 8'h30; w_mem[3] = 4'hF; store_data[3] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1'b0;
        mreq[3] = 1'b0; w_mem[3] = 4'h0;
        #1;
        checks++;
        if (mres[3] !== 1'b0 || load_data[3] !== 32'h0) begin
            errors++;
            $display("FAIL midwait_reset_outputs: mres=%b load_data=%h, required 0 and 00000000", mres[3], load_data[3]);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        $display("reset asserted two cycles into wait on dut3");
        txn(3, 8'h30, 4'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midwait_no_write: load_data=%h, required 00000000", rd);
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL midwait_post_latency: %0d edges, required 5", lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_word_rw;
        test_byte_masks;
        test_input_stability;
        test_hold;
        test_latency_sweep;
        test_reset_mid_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_responder
